fetch_queue: RTL and testbench

- Instruction fetch queue between the frontend (writer of fetch_entry_t bundles) and the decode stage (reader).
- Accepts up to INSTR_PER_FETCH entries per cycle. Compacts valid lanes in program order. Truncates each bundle after a predicted-taken branch or an exception.
- Delivers one fetch_entry_t per cycle to decode under a valid/ack handshake.
- A flush from the controller empties the queue in one cycle.

---
 rtl/fetch_queue.sv | 154 +++++++++++++++
 tb/tb_fetch_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: compacts and truncates multi-lane fetch bundles into a
// circular buffer and hands entries to decode one per cycle under valid/ack.
package tortoise_pkg;
    localparam int unsigned IFQ_DEPTH       = 8;
    localparam int unsigned INSTR_PER_FETCH = 2;

    typedef struct packed {
        logic        valid;
        logic [3:0]  cause;
    } exception_t;

    typedef struct packed {
        logic        is_taken;
        logic [31:0] target;
    } predict_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] instr;
        exception_t  ex;
        predict_t    predict;
    } fetch_entry_t;
endpackage

module fetch_queue_chk #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = 4
) (
    input logic          clk_i,
    input logic          rst_ni,
    input logic [CW-1:0] count_i
);
    // Occupancy can never exceed the storage size.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_i <= CW'(DEPTH));
endmodule

module fetch_queue
    import tortoise_pkg::*;
#(
    parameter int unsigned DEPTH    = IFQ_DEPTH,
    parameter int unsigned IN_WIDTH = INSTR_PER_FETCH
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        fetch_valid_i,
    input  fetch_entry_t [IN_WIDTH-1:0] fetch_entry_i,
    output logic                        fetch_ready_o,
    output logic                        decode_valid_o,
    output fetch_entry_t                decode_entry_o,
    input  logic                        decode_ack_i,
    output logic [$clog2(DEPTH):0]      count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [IN_WIDTH-1:0] keep_s;
    logic [PW-1:0]       lane_off_s [IN_WIDTH];
    logic [CW-1:0]       n_push_s;
    logic                accept_s;
    logic                pop_s;

    // A valid lane that is taken or faulting ends the bundle; it is kept, younger lanes are not.
    always_comb begin
        logic          stop_v;
        logic [PW-1:0] run_v;
        stop_v   = 1'b0;
        run_v    = '0;
        keep_s   = '0;
        n_push_s = '0;
        for (int i = 0; i < int'(IN_WIDTH); i++) begin
            lane_off_s[i] = run_v;
            if (fetch_entry_i[i].valid && !stop_v) begin
                keep_s[i] = 1'b1;
                run_v     = run_v + PW'(1'b1);
                n_push_s  = n_push_s + CW'(1'b1);
                if (fetch_entry_i[i].ex.valid || fetch_entry_i[i].predict.is_taken) begin
                    stop_v = 1'b1;
                end else begin
                    stop_v = stop_v;
                end
            end else begin
                keep_s[i] = 1'b0;
            end
        end
    end

    assign fetch_ready_o  = (CW'(DEPTH) - count_q) >= CW'(IN_WIDTH);
    assign decode_valid_o = (count_q != '0);
    assign accept_s       = fetch_valid_i & fetch_ready_o & ~flush_i;
    assign pop_s          = decode_valid_o & decode_ack_i & ~flush_i;
    assign count_o        = count_q;

    // Next pointer and occupancy; flush wins over any push or pop in the same cycle.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (accept_s) begin
                wr_ptr_d = wr_ptr_q + n_push_s[PW-1:0];
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            count_d = count_q + (accept_s ? n_push_s : CW'(1'b0)) - CW'(pop_s);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless outside [rd_ptr, rd_ptr+count) so no reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(IN_WIDTH); i++) begin
            if (accept_s && keep_s[i]) begin
                mem_q[wr_ptr_q + lane_off_s[i]] <= fetch_entry_i[i];
            end
        end
    end

    assign decode_entry_o = decode_valid_o ? mem_q[rd_ptr_q] : '0;

    fetch_queue_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .count_i(count_q)
    );
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations.
module tb_fetch_queue;
    import tortoise_pkg::*;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               flush_i;
    logic               fetch_valid_i;
    fetch_entry_t [1:0] fetch_entry_i;
    logic               fetch_ready_o;
    logic               decode_valid_o;
    fetch_entry_t       decode_entry_o;
    logic               decode_ack_i;
    logic [3:0]         count_o;

    int errors = 0;
    int checks = 0;
    fetch_entry_t mq[$];
    bit last_acc;

    fetch_queue #(.DEPTH(8), .IN_WIDTH(2)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_entry_i (fetch_entry_i),
        .fetch_ready_o (fetch_ready_o),
        .decode_valid_o(decode_valid_o),
        .decode_entry_o(decode_entry_o),
        .decode_ack_i  (decode_ack_i),
        .count_o       (count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic fetch_entry_t mk(input logic [31:0] addr, input logic v,
                                        input logic tk, input logic exv);
        fetch_entry_t e;
        e                  = '0;
        e.valid            = v;
        e.addr             = addr;
        e.instr            = addr ^ 32'hDEAD_BEEF;
        e.ex.valid         = exv;
        e.ex.cause         = exv ? 4'h2 : 4'h0;
        e.predict.is_taken = tk;
        e.predict.target   = tk ? addr + 32'h0000_0100 : 32'h0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        fetch_entry_t exp_e;
        exp_e = (mq.size() != 0) ? mq[0] : '0;
        chk("ready", 128'(fetch_ready_o), 128'((8 - mq.size()) >= 2));
        chk("valid", 128'(decode_valid_o), 128'(mq.size() != 0));
        chk("count", 128'(count_o), 128'(mq.size()));
        chk("entry", 128'(decode_entry_o), 128'(exp_e));
    endtask

    // One clock: drive inputs, advance the model across the edge, check on the falling edge.
    task automatic cyc(input logic v, input fetch_entry_t l0, input fetch_entry_t l1,
                       input logic ack, input logic fl);
        bit acc, pop;
        fetch_entry_t lanes [2];
        fetch_valid_i    = v;
        fetch_entry_i[0] = l0;
        fetch_entry_i[1] = l1;
        decode_ack_i     = ack;
        flush_i          = fl;
        acc      = v && ((8 - mq.size()) >= 2) && !fl;
        pop      = (mq.size() != 0) && ack && !fl;
        last_acc = acc;
        lanes[0] = l0;
        lanes[1] = l1;
        @(posedge clk_i);
        if (fl) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                foreach (lanes[i]) begin
                    if (lanes[i].valid) begin
                        mq.push_back(lanes[i]);
                        if (lanes[i].ex.valid || lanes[i].predict.is_taken) break;
                    end
                end
            end
        end
        @(negedge clk_i);
        compare_model();
    endtask

    task automatic idle(input logic ack);
        cyc(1'b0, '0, '0, ack, 1'b0);
    endtask

    task automatic push2(input logic [31:0] a);
        cyc(1'b1, mk(a, 1'b1, 1'b0, 1'b0), mk(a + 32'd4, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    endtask

    task automatic push1(input logic [31:0] a);
        cyc(1'b1, mk(a, 1'b1, 1'b0, 1'b0), '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_entry_i = '0;
        decode_ack_i  = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_ready", 128'(fetch_ready_o), 128'(1));
        chk("rst_valid", 128'(decode_valid_o), 128'(0));
        chk("rst_count", 128'(count_o), 128'(0));
        chk("rst_entry", 128'(decode_entry_o), 128'(0));
        rst_ni = 1'b1;
        idle(1'b0);

        // Basic push and in-order pop.
        push2(32'h8000_0000);
        chk("p1_count", 128'(count_o), 128'(2));
        chk("p1_addr", 128'(decode_entry_o.addr), 128'(32'h8000_0000));
        idle(1'b1);
        chk("p1_addr_b", 128'(decode_entry_o.addr), 128'(32'h8000_0004));
        idle(1'b1);
        chk("p1_empty", 128'(decode_valid_o), 128'(0));
        idle(1'b1);
        chk("ack_empty_cnt", 128'(count_o), 128'(0));

        // Fill to 7 and back-pressure.
        push2(32'h8000_0100);
        push2(32'h8000_0108);
        push2(32'h8000_0110);
        push1(32'h8000_0118);
        chk("full_count", 128'(count_o), 128'(7));
        chk("full_ready", 128'(fetch_ready_o), 128'(0));
        push2(32'h8000_0200);
        chk("full_hold", 128'(count_o), 128'(7));
        idle(1'b1);
        chk("after_ack_cnt", 128'(count_o), 128'(6));
        chk("after_ack_rdy", 128'(fetch_ready_o), 128'(1));
        repeat (6) idle(1'b1);

        // Truncation after taken branch and after exception.
        cyc(1'b1, mk(32'h8000_0300, 1'b1, 1'b1, 1'b0), mk(32'h8000_0304, 1'b1, 1'b0, 1'b0),
            1'b0, 1'b0);
        chk("taken_cnt", 128'(count_o), 128'(1));
        idle(1'b1);
        chk("taken_drop", 128'(decode_valid_o), 128'(0));
        cyc(1'b1, mk(32'h8000_0400, 1'b1, 1'b0, 1'b1), mk(32'h8000_0404, 1'b1, 1'b0, 1'b0),
            1'b0, 1'b0);
        chk("ex_cnt", 128'(count_o), 128'(1));
        idle(1'b1);

        // Invalid lane 0, then invalid-but-flagged lane 0 (not a terminator), then empty bundle.
        cyc(1'b1, '0, mk(32'h8000_0010, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
        chk("gap_addr", 128'(decode_entry_o.addr), 128'(32'h8000_0010));
        cyc(1'b1, mk(32'h8000_0500, 1'b0, 1'b1, 1'b0), mk(32'h8000_0504, 1'b1, 1'b0, 1'b0),
            1'b1, 1'b0);
        chk("inv_taken_addr", 128'(decode_entry_o.addr), 128'(32'h8000_0504));
        cyc(1'b1, '0, '0, 1'b1, 1'b0);
        chk("zero_push", 128'(count_o), 128'(0));

        // Flush beats simultaneous push and ack.
        push2(32'h8000_0600);
        push2(32'h8000_0608);
        push1(32'h8000_0610);
        chk("pre_flush", 128'(count_o), 128'(5));
        cyc(1'b1, mk(32'h8000_0700, 1'b1, 1'b0, 1'b0), mk(32'h8000_0704, 1'b1, 1'b0, 1'b0),
            1'b1, 1'b1);
        chk("flush_cnt", 128'(count_o), 128'(0));
        chk("flush_valid", 128'(decode_valid_o), 128'(0));

        // Twenty entries with continuous ack, crossing the wrap point.
        begin
            int sent = 0;
            for (int c = 0; c < 100 && sent < 10; c++) begin
                cyc(1'b1, mk(32'h9000_0000 + 32'(sent * 8), 1'b1, 1'b0, 1'b0),
                    mk(32'h9000_0004 + 32'(sent * 8), 1'b1, 1'b0, 1'b0), 1'b1, 1'b0);
                chk("wrap_bound", 128'(count_o <= 4'd8), 128'(1));
                if (last_acc) sent++;
            end
            chk("wrap_sent", 128'(sent), 128'(10));
            for (int c = 0; c < 20 && mq.size() != 0; c++) idle(1'b1);
            chk("wrap_drained", 128'(count_o), 128'(0));
        end

        // Asynchronous reset mid-operation, observed with no clock edge.
        push2(32'h8000_0800);
        rst_ni = 1'b0;
        #1;
        mq.delete();
        chk("arst_count", 128'(count_o), 128'(0));
        chk("arst_valid", 128'(decode_valid_o), 128'(0));
        chk("arst_entry", 128'(decode_entry_o), 128'(0));
        chk("arst_ready", 128'(fetch_ready_o), 128'(1));
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
